// File: rtl/alu_pipe.sv
// alu_pipe: WIDTH-bit two-stage pipelined ALU with valid/ready handshake on both sides.
// Stage 1 shifts LHS and combines it with RHS through a 4-bit truth table.
// Stage 2 adds a selected second operand and carry, then retires the result and sticky flags.
// Optional feature macro: ALU_ROTATE_EN builds rotate, swap-halves and bit-reverse shifts.
// DELAY_RISE / DELAY_FALL only describe simulation output delays; this model is zero-delay.

module alu_pipe #(
    parameter int WIDTH      = 8,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] LHS,
    input  logic [WIDTH-1:0] RHS,
    input  logic [2:0]       SHIFT_OP,
    input  logic [3:0]       LOGIC_OP,
    input  logic [1:0]       B_SEL,
    input  logic [1:0]       CARRY_SEL,
    input  logic             FLAG_WE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             OVERFLOW_FLAG,
    output logic             NEGATIVE_FLAG,
    output logic             ZERO_FLAG,
    output logic             ARITH_CARRY_FLAG,
    output logic             LOGIC_CARRY_FLAG
);

    // Reject parameter sets the datapath cannot support (odd widths break swap-halves).
    if ((WIDTH < 4) || ((WIDTH % 2) != 0) || (DELAY_RISE < 0) || (DELAY_FALL < 0)) begin : g_badParams
        $error("alu_pipe: WIDTH must be even and >= 4, delays must be non-negative");
    end

    logic             advance;
    logic [WIDTH-1:0] shifted;
    logic             shiftCarry;
    logic [WIDTH-1:0] logic_d;

    logic             v1_q;
    logic [WIDTH-1:0] logic_q;
    logic             logicCarry_q;
    logic [WIDTH-1:0] rhs_q;
    logic [1:0]       bSel_q;
    logic [1:0]       carrySel_q;
    logic             flagWe_q;

    logic [WIDTH-1:0] bOperand;
    logic             carryIn;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             overflow_d;

    logic             outValid_q;
    logic [WIDTH-1:0] result_q;
    logic             overflow_q;
    logic             negative_q;
    logic             zero_q;
    logic             arithCarry_q;
    logic             logicCarry2_q;

    // The whole pipe moves only when the output slot is empty or being drained.
    assign advance  = !outValid_q || OUT_READY;
    assign IN_READY = advance;

    // Stage-1 shifter; LC is the bit pushed off the end by the plain shifts only.
    always_comb begin
        shifted    = LHS;
        shiftCarry = 1'b0;
        case (SHIFT_OP)
            3'b001: begin
                shifted    = {LHS[WIDTH-2:0], 1'b0};
                shiftCarry = LHS[WIDTH-1];
            end
            3'b010: begin
                shifted    = {1'b0, LHS[WIDTH-1:1]};
                shiftCarry = LHS[0];
            end
            3'b011: begin
                shifted    = {LHS[WIDTH-1], LHS[WIDTH-1:1]};
                shiftCarry = LHS[0];
            end
`ifdef ALU_ROTATE_EN
            3'b100: shifted = {LHS[WIDTH-2:0], LHS[WIDTH-1]};
            3'b101: shifted = {LHS[0], LHS[WIDTH-1:1]};
            3'b110: shifted = {LHS[WIDTH/2-1:0], LHS[WIDTH-1:WIDTH/2]};
            3'b111: begin
                for (int i = 0; i < WIDTH; i++) begin
                    shifted[i] = LHS[WIDTH-1-i];
                end
            end
`endif
            default: begin
                shifted    = LHS;
                shiftCarry = 1'b0;
            end
        endcase
    end

    // Bitwise truth-table lookup indexed by {shifted bit, RHS bit}.
    always_comb begin
        logic_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            logic_d[i] = LOGIC_OP[{shifted[i], RHS[i]}];
        end
    end

    // Stage-2 adder; carry-select 10 reads the live flag so chained ops need no bubble.
    always_comb begin
        case (bSel_q)
            2'b00:   bOperand = '0;
            2'b01:   bOperand = rhs_q;
            2'b10:   bOperand = ~rhs_q;
            default: bOperand = '1;
        endcase
        case (carrySel_q)
            2'b00:   carryIn = 1'b0;
            2'b01:   carryIn = 1'b1;
            2'b10:   carryIn = arithCarry_q;
            default: carryIn = logicCarry_q;
        endcase
        {carry_d, result_d} = {1'b0, logic_q} + {1'b0, bOperand} + {{WIDTH{1'b0}}, carryIn};
        overflow_d = (logic_q[WIDTH-1] == bOperand[WIDTH-1]) && (result_d[WIDTH-1] != logic_q[WIDTH-1]);
    end

    // Control/visible state: reset wins, otherwise shift valids and retire results on advance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q          <= 1'b0;
            outValid_q    <= 1'b0;
            result_q      <= '0;
            overflow_q    <= 1'b0;
            negative_q    <= 1'b0;
            zero_q        <= 1'b0;
            arithCarry_q  <= 1'b0;
            logicCarry2_q <= 1'b0;
        end else if (advance) begin
            v1_q       <= IN_VALID;
            outValid_q <= v1_q;
            if (v1_q) begin
                result_q <= result_d;
                if (flagWe_q) begin
                    overflow_q    <= overflow_d;
                    negative_q    <= result_d[WIDTH-1];
                    zero_q        <= (result_d == '0);
                    arithCarry_q  <= carry_d;
                    logicCarry2_q <= logicCarry_q;
                end
            end
        end
    end

    // Stage-1 payload is only meaningful alongside v1_q, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (!RST && advance && IN_VALID) begin
            logic_q      <= logic_d;
            logicCarry_q <= shiftCarry;
            rhs_q        <= RHS;
            bSel_q       <= B_SEL;
            carrySel_q   <= CARRY_SEL;
            flagWe_q     <= FLAG_WE;
        end
    end

    assign OUT_VALID        = outValid_q;
    assign RESULT           = result_q;
    assign OVERFLOW_FLAG    = overflow_q;
    assign NEGATIVE_FLAG    = negative_q;
    assign ZERO_FLAG        = zero_q;
    assign ARITH_CARRY_FLAG = arithCarry_q;
    assign LOGIC_CARRY_FLAG = logicCarry2_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe at WIDTH 8.
// Flags are compared as {OVERFLOW, NEGATIVE, ZERO, ARITH_CARRY, LOGIC_CARRY}.

module tb_alu_pipe;

    logic       CLK = 1'b0;
    logic       RST;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] LHS;
    logic [7:0] RHS;
    logic [2:0] SHIFT_OP;
    logic [3:0] LOGIC_OP;
    logic [1:0] B_SEL;
    logic [1:0] CARRY_SEL;
    logic       FLAG_WE;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] RESULT;
    logic       OVERFLOW_FLAG, NEGATIVE_FLAG, ZERO_FLAG, ARITH_CARRY_FLAG, LOGIC_CARRY_FLAG;
    logic [4:0] flags;

    int testsRun  = 0;
    int failCount = 0;

    assign flags = {OVERFLOW_FLAG, NEGATIVE_FLAG, ZERO_FLAG, ARITH_CARRY_FLAG, LOGIC_CARRY_FLAG};

    alu_pipe #(.WIDTH(8), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .LHS(LHS), .RHS(RHS), .SHIFT_OP(SHIFT_OP), .LOGIC_OP(LOGIC_OP),
        .B_SEL(B_SEL), .CARRY_SEL(CARRY_SEL), .FLAG_WE(FLAG_WE),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT),
        .OVERFLOW_FLAG(OVERFLOW_FLAG), .NEGATIVE_FLAG(NEGATIVE_FLAG), .ZERO_FLAG(ZERO_FLAG),
        .ARITH_CARRY_FLAG(ARITH_CARRY_FLAG), .LOGIC_CARRY_FLAG(LOGIC_CARRY_FLAG)
    );

    always #5 CLK = ~CLK;

    // Present one operation; caller is sitting just after a falling edge.
    task automatic drive(input logic [7:0] lhs, input logic [7:0] rhs, input logic [2:0] sh,
                         input logic [3:0] lo, input logic [1:0] bs, input logic [1:0] cs,
                         input logic fwe);
        IN_VALID  = 1'b1;
        LHS       = lhs;
        RHS       = rhs;
        SHIFT_OP  = sh;
        LOGIC_OP  = lo;
        B_SEL     = bs;
        CARRY_SEL = cs;
        FLAG_WE   = fwe;
    endtask

    // Advance one clock and park on the falling edge for sampling/driving.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
        drive(8'h00, 8'h00, 3'b000, 4'b1100, 2'b00, 2'b00, 1'b0);
        IN_VALID = 1'b0;
        step(); step();
        RST = 1'b0;
        testsRun++;
        if (OUT_VALID !== 1'b0 || RESULT !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL reset_out: valid=%b result=%h, expected 0/00", OUT_VALID, RESULT);
        end
        testsRun++;
        if (flags !== 5'b00000 || IN_READY !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_flags: flags=%b ready=%b, expected 00000/1", flags, IN_READY);
        end
    endtask

    task automatic test_add();
        drive(8'h7F, 8'h01, 3'b000, 4'b1100, 2'b01, 2'b00, 1'b1);
        step();
        IN_VALID = 1'b0;
        step();
        testsRun++;
        if (OUT_VALID !== 1'b1 || RESULT !== 8'h80 || flags !== 5'b11000) begin
            failCount++;
            $display("[TB] FAIL add_7f_01: valid=%b result=%h flags=%b, expected 1/80/11000", OUT_VALID, RESULT, flags);
        end
        step();
        testsRun++;
        if (OUT_VALID !== 1'b0 || RESULT !== 8'h80 || flags !== 5'b11000) begin
            failCount++;
            $display("[TB] FAIL add_bubble: valid=%b result=%h flags=%b, expected 0/80/11000", OUT_VALID, RESULT, flags);
        end
    endtask

    task automatic test_back_to_back();
        drive(8'hFF, 8'h01, 3'b000, 4'b1100, 2'b01, 2'b00, 1'b1);
        step();
        drive(8'h01, 8'h00, 3'b000, 4'b1100, 2'b01, 2'b10, 1'b1);
        step();
        IN_VALID = 1'b0;
        testsRun++;
        if (OUT_VALID !== 1'b1 || RESULT !== 8'h00 || flags !== 5'b00110) begin
            failCount++;
            $display("[TB] FAIL chain_low: valid=%b result=%h flags=%b, expected 1/00/00110", OUT_VALID, RESULT, flags);
        end
        step();
        testsRun++;
        if (OUT_VALID !== 1'b1 || RESULT !== 8'h02 || flags !== 5'b00000) begin
            failCount++;
            $display("[TB] FAIL chain_high: valid=%b result=%h flags=%b, expected 1/02/00000", OUT_VALID, RESULT, flags);
        end
        step();
    endtask

    task automatic test_sub();
        drive(8'h05, 8'h05, 3'b000, 4'b1100, 2'b10, 2'b01, 1'b1);
        step();
        drive(8'h10, 8'h20, 3'b000, 4'b1100, 2'b01, 2'b00, 1'b0);
        step();
        IN_VALID = 1'b0;
        testsRun++;
        if (RESULT !== 8'h00 || flags !== 5'b00110) begin
            failCount++;
            $display("[TB] FAIL sub_5_5: result=%h flags=%b, expected 00/00110", RESULT, flags);
        end
        step();
        testsRun++;
        if (RESULT !== 8'h30 || flags !== 5'b00110) begin
            failCount++;
            $display("[TB] FAIL flag_we_0: result=%h flags=%b, expected 30/00110", RESULT, flags);
        end
        step();
    endtask

    task automatic test_shift();
        logic [7:0] rolResult;
        logic [4:0] rolFlags;
`ifdef ALU_ROTATE_EN
        rolResult = 8'h03; rolFlags = 5'b00000;
`else
        rolResult = 8'h81; rolFlags = 5'b01000;
`endif
        drive(8'h81, 8'h00, 3'b001, 4'b1100, 2'b00, 2'b00, 1'b1);
        step();
        drive(8'h81, 8'h00, 3'b100, 4'b1100, 2'b00, 2'b00, 1'b1);
        step();
        testsRun++;
        if (RESULT !== 8'h02 || flags !== 5'b00001) begin
            failCount++;
            $display("[TB] FAIL shl_81: result=%h flags=%b, expected 02/00001", RESULT, flags);
        end
        drive(8'h81, 8'h00, 3'b011, 4'b1100, 2'b00, 2'b00, 1'b1);
        step();
        testsRun++;
        if (RESULT !== rolResult || flags !== rolFlags) begin
            failCount++;
            $display("[TB] FAIL rol_81: result=%h flags=%b, expected %h/%b", RESULT, flags, rolResult, rolFlags);
        end
        drive(8'hF0, 8'h3C, 3'b000, 4'b0110, 2'b00, 2'b00, 1'b1);
        step();
        testsRun++;
        if (RESULT !== 8'hC0 || flags !== 5'b01001) begin
            failCount++;
            $display("[TB] FAIL asr_81: result=%h flags=%b, expected c0/01001", RESULT, flags);
        end
        drive(8'h00, 8'h00, 3'b000, 4'b1100, 2'b11, 2'b00, 1'b1);
        step();
        testsRun++;
        if (RESULT !== 8'hCC || flags !== 5'b01000) begin
            failCount++;
            $display("[TB] FAIL xor_f0_3c: result=%h flags=%b, expected cc/01000", RESULT, flags);
        end
        drive(8'h80, 8'h00, 3'b001, 4'b1100, 2'b00, 2'b11, 1'b1);
        step();
        testsRun++;
        if (RESULT !== 8'hFF || flags !== 5'b01000) begin
            failCount++;
            $display("[TB] FAIL decrement_00: result=%h flags=%b, expected ff/01000", RESULT, flags);
        end
        drive(8'h81, 8'h00, 3'b010, 4'b1100, 2'b00, 2'b00, 1'b1);
        step();
        testsRun++;
        if (RESULT !== 8'h01 || flags !== 5'b00001) begin
            failCount++;
            $display("[TB] FAIL carry_sel_lc: result=%h flags=%b, expected 01/00001", RESULT, flags);
        end
        IN_VALID = 1'b0;
        step();
        testsRun++;
        if (RESULT !== 8'h40 || flags !== 5'b00001) begin
            failCount++;
            $display("[TB] FAIL shr_81: result=%h flags=%b, expected 40/00001", RESULT, flags);
        end
        step();
    endtask

    task automatic test_backpressure();
        OUT_READY = 1'b0;
        drive(8'h11, 8'h01, 3'b000, 4'b1100, 2'b01, 2'b00, 1'b0);
        step();
        testsRun++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bp_first: ready=%b valid=%b, expected 1/0", IN_READY, OUT_VALID);
        end
        drive(8'h22, 8'h01, 3'b000, 4'b1100, 2'b01, 2'b00, 1'b0);
        step();
        testsRun++;
        if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || RESULT !== 8'h12) begin
            failCount++;
            $display("[TB] FAIL bp_full: ready=%b valid=%b result=%h, expected 0/1/12", IN_READY, OUT_VALID, RESULT);
        end
        drive(8'h33, 8'h01, 3'b000, 4'b1100, 2'b01, 2'b00, 1'b0);
        step(); step();
        testsRun++;
        if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || RESULT !== 8'h12) begin
            failCount++;
            $display("[TB] FAIL bp_hold: ready=%b valid=%b result=%h, expected 0/1/12", IN_READY, OUT_VALID, RESULT);
        end
        OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0;
        testsRun++;
        if (OUT_VALID !== 1'b1 || RESULT !== 8'h23) begin
            failCount++;
            $display("[TB] FAIL bp_second: valid=%b result=%h, expected 1/23", OUT_VALID, RESULT);
        end
        step();
        testsRun++;
        if (OUT_VALID !== 1'b1 || RESULT !== 8'h34) begin
            failCount++;
            $display("[TB] FAIL bp_third: valid=%b result=%h, expected 1/34", OUT_VALID, RESULT);
        end
        step();
        testsRun++;
        if (OUT_VALID !== 1'b0 || RESULT !== 8'h34) begin
            failCount++;
            $display("[TB] FAIL bp_drained: valid=%b result=%h, expected 0/34", OUT_VALID, RESULT);
        end
    endtask

    task automatic test_reset_inflight();
        drive(8'h7F, 8'h01, 3'b000, 4'b1100, 2'b01, 2'b00, 1'b1);
        step();
        drive(8'h40, 8'h02, 3'b000, 4'b1100, 2'b01, 2'b00, 1'b1);
        step();
        testsRun++;
        if (RESULT !== 8'h80 || flags !== 5'b11000) begin
            failCount++;
            $display("[TB] FAIL pre_reset: result=%h flags=%b, expected 80/11000", RESULT, flags);
        end
        RST = 1'b1;
        drive(8'h01, 8'h01, 3'b000, 4'b1100, 2'b01, 2'b00, 1'b1);
        step();
        RST = 1'b0;
        IN_VALID = 1'b0;
        testsRun++;
        if (OUT_VALID !== 1'b0 || RESULT !== 8'h00 || flags !== 5'b00000) begin
            failCount++;
            $display("[TB] FAIL reset_inflight: valid=%b result=%h flags=%b, expected 0/00/00000", OUT_VALID, RESULT, flags);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            testsRun++;
            if (OUT_VALID !== 1'b0 || RESULT !== 8'h00) begin
                failCount++;
                $display("[TB] FAIL reset_discard%0d: valid=%b result=%h, expected 0/00", i, OUT_VALID, RESULT);
            end
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_add();
        test_back_to_back();
        test_sub();
        test_shift();
        test_backpressure();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised successor to the 8-bit two-stage ALU: a WIDTH-bit, two-stage pipelined ALU with a valid/ready handshake on both sides, per-operation control latched alongside the operands, and per-operation flag write enable. Sits between the instruction dispatch/register-read stage and writeback. It supports multi-word add/sub chains through the registered arithmetic carry flag.

## Interface
- WIDTH, 8: datapath width; even, ≥ 4.
- DELAY_RISE, 0: simulation rise delay on registered outputs.
- DELAY_FALL, 0: simulation fall delay on registered outputs.

- CLK  in  1  single clock; all state changes on rising edge.
- RST  in  1  reset; synchronous, active-high.
- IN_VALID  in  1  operation presented.
- IN_READY  out  1  operation accepted on this edge if IN_VALID.
- LHS, RHS  in  WIDTH  operands.
- SHIFT_OP  in  3  shift applied to LHS (stage 1).
- LOGIC_OP  in  4  truth table combining shifted LHS with RHS (stage 1).
- B_SEL  in  2  adder second operand: 00 zero, 01 RHS, 10 ~RHS, 11 all ones.
- CARRY_SEL  in  2  adder carry in: 00 0, 01 1, 10 ARITH_CARRY_FLAG, 11 this op's logic carry.
- FLAG_WE  in  1  op updates flags when it retires.
- OUT_VALID  out  1  RESULT holds a retired op.
- OUT_READY  in  1  consumer takes RESULT this edge.
- RESULT  out  WIDTH  result.
- OVERFLOW_FLAG, NEGATIVE_FLAG, ZERO_FLAG, ARITH_CARRY_FLAG, LOGIC_CARRY_FLAG  out  1 each  sticky flag registers.

## Operation
- Stage 1 (on accept): S = shift(LHS); LC = bit shifted out (0 for no shift and all rotates); L[i] = LOGIC_OP[{S[i], RHS[i]}]. Latch L, LC, RHS, B_SEL, CARRY_SEL, FLAG_WE, V1 = 1.
- SHIFT_OP: 000 none; 001 SHL, 0 in; 010 SHR, 0 in; 011 ASR; 100 ROL; 101 ROR; 110 swap halves; 111 bit reverse.
- Stage 2: {C, R} = L + B + cin at WIDTH+1 bits. Latch R into RESULT and set OUT_VALID.
- Stage 2 flags, when FLAG_WE: ARITH_CARRY = C; LOGIC_CARRY = LC; NEGATIVE = R[WIDTH-1]; ZERO = (R == 0); OVERFLOW = (L msb == B msb) && (R msb != L msb). With FLAG_WE = 0, all five flags hold.
- Add: LOGIC_OP 1100, B_SEL 01, CARRY_SEL 00. Sub: LOGIC_OP 1100, B_SEL 10, CARRY_SEL 01. Multi-word: CARRY_SEL 10.
- Stall: advance = !OUT_VALID || OUT_READY; IN_READY = advance. When advance is 0, all pipeline registers and flags hold. When advance is 1 and !IN_VALID, a bubble enters stage 1 (V1 = 0).
- A bubble reaching stage 2 clears OUT_VALID and leaves RESULT and the flags unchanged.
- RST: V1, OUT_VALID, RESULT and all flags are cleared to 0. RST takes priority over any accept or advance on the same edge, and in-flight ops are discarded.

## Timing
- Latency 2: op accepted at edge k; RESULT and flags are visible after edge k+1, with no stall.
- Throughput: one op per cycle while OUT_READY = 1.
- Carry chaining: CARRY_SEL 10 reads ARITH_CARRY_FLAG during the op's stage-2 cycle. That value already reflects the immediately preceding op if that op had FLAG_WE = 1, so back-to-back chains need no bubble.
- Reset values: IN_READY 1 (follows advance), OUT_VALID 0, RESULT 0, all flags 0.
- Outputs are registered; DELAY_RISE and DELAY_FALL apply to registered outputs in simulation only.

## Configuration
- ALU_ROTATE_EN defined: SHIFT_OP 100–111 operate as listed.
- ALU_ROTATE_EN undefined: SHIFT_OP 100–111 behave as 000 (S = LHS, LC = 0), and the rotate, swap and reverse logic is not built.

## Test plan
- Reset, then add (WIDTH 8): LHS 0x7F, RHS 0x01, add, FLAG_WE 1 -> two cycles later RESULT 0x80, OVERFLOW 1, NEGATIVE 1, ZERO 0, ARITH_CARRY 0.
- Back-to-back 16-bit add as 0x01FF + 0x0001: low word 0xFF + 0x01 (CARRY_SEL 00), then high word 0x01 + 0x00 (CARRY_SEL 10) on the next cycle -> RESULTs 0x00 (ZERO 1, ARITH_CARRY 1), then 0x02.
- Sub: LHS 0x05, RHS 0x05 -> RESULT 0x00, ZERO 1, ARITH_CARRY 1. An op with FLAG_WE 0 issued next leaves the flags unchanged.
- Shift: SHL on LHS 0x81 with LOGIC_OP 1100, B_SEL 00, CARRY_SEL 00 -> RESULT 0x02, LOGIC_CARRY 1. With ALU_ROTATE_EN, ROL on the same LHS -> 0x03. Without it, ROL -> 0x81.
- Backpressure: hold OUT_READY 0 with three ops issued -> IN_READY drops once OUT_VALID = 1; RESULT stays stable; no op is lost or duplicated when OUT_READY returns to 1.
- Assert RST for one cycle with two ops in flight -> the next cycle shows OUT_VALID 0, RESULT 0 and all flags 0, and neither op ever emerges.
